// File: rtl/forest_vote_accumulator_pkg.sv
// Shared forest geometry, accumulator widths and control state encodings.
// No logic; compile-time constants plus one lane-extraction helper.
// Used by the vote accumulator and the forest control path.
package forest_vote_accumulator_pkg;

    localparam int NUM_TREES   = 8;
    localparam int DEC_W       = 256;
    localparam int CLASS_W     = 8;
    localparam int NUM_CLASSES = DEC_W / CLASS_W;
    localparam int SUM_W       = CLASS_W + $clog2(NUM_TREES);
    localparam int CLS_W       = $clog2(NUM_CLASSES);
    localparam int TREE_W      = $clog2(NUM_TREES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } vote_state_t;

    // Zero-extended class lane k of a decision vector, ready for summing.
    function automatic logic [SUM_W-1:0] lane_ext(input logic [DEC_W-1:0] v, input int unsigned k);
        return SUM_W'(v[k*CLASS_W +: CLASS_W]);
    endfunction

endpackage

// File: rtl/vote_argmax_scan.sv
// Sequential argmax over the class sums, one class per cycle after a start pulse.
// Latency: NUM_CLASSES cycles from start; done is high during the last compare cycle.
// No backpressure; best/best_idx hold their value until the next start or reset.
module vote_argmax_scan
    import forest_vote_accumulator_pkg::*;
(
    input  logic             clk,
    input  logic             resetall,
    input  logic             start,
    input  logic [SUM_W-1:0] val,
    output logic [CLS_W-1:0] cls_idx,
    output logic [SUM_W-1:0] best,
    output logic [CLS_W-1:0] best_idx,
    output logic             done
);

    logic active;

    assign done = active && (cls_idx == CLS_W'(NUM_CLASSES - 1));

    // Walk the classes in order; strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (resetall) begin
            active   <= 1'b0;
            cls_idx  <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (start) begin
            active   <= 1'b1;
            cls_idx  <= '0;
            best     <= '0;
            best_idx <= '0;
        end else if (active) begin
            if (val > best) begin
                best     <= val;
                best_idx <= cls_idx;
            end
            cls_idx <= cls_idx + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/forest_vote_accumulator.sv
// Sums per-class scores over enabled trees, then picks the highest-scoring class.
// Latency: 40 cycles from input handshake to out_valid_o (8 accumulate + 32 scan).
// Accepts input only when idle; result held in DONE until out_ready_i.
module forest_vote_accumulator
    import forest_vote_accumulator_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetall,
    input  logic [DEC_W-1:0]     decision1_i,
    input  logic [DEC_W-1:0]     decision2_i,
    input  logic [DEC_W-1:0]     decision3_i,
    input  logic [DEC_W-1:0]     decision4_i,
    input  logic [DEC_W-1:0]     decision5_i,
    input  logic [DEC_W-1:0]     decision6_i,
    input  logic [DEC_W-1:0]     decision7_i,
    input  logic [DEC_W-1:0]     decision8_i,
    input  logic [NUM_TREES-1:0] tree_en_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CLS_W-1:0]     class_o,
    output logic [SUM_W-1:0]     score_o,
    output logic                 busy_o
);

    vote_state_t          state;
    logic [TREE_W-1:0]    tree_idx;
    logic [NUM_TREES-1:0] tree_en_q;
    logic [DEC_W-1:0]     dec_q [NUM_TREES];
    logic [SUM_W-1:0]     acc   [NUM_CLASSES];
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic                 scan_start;
    logic                 scan_done;
    logic [CLS_W-1:0]     scan_idx;
    logic [SUM_W-1:0]     scan_best;
    logic [CLS_W-1:0]     scan_best_idx;

    // Scan is armed on the last accumulate cycle so it begins right as the sums settle.
    assign scan_start = (state == ACCUM) && (tree_idx == TREE_W'(NUM_TREES - 1));

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign class_o     = scan_best_idx;
    assign score_o     = scan_best;

    // Capture the decision set on the input handshake; contents are don't-care otherwise.
    always_ff @(posedge clk) begin
        if (in_ready_q && in_valid_i) begin
            dec_q[0] <= decision1_i;
            dec_q[1] <= decision2_i;
            dec_q[2] <= decision3_i;
            dec_q[3] <= decision4_i;
            dec_q[4] <= decision5_i;
            dec_q[5] <= decision6_i;
            dec_q[6] <= decision7_i;
            dec_q[7] <= decision8_i;
        end
    end

    // Control FSM plus the per-class accumulator array, one tree per cycle.
    always_ff @(posedge clk) begin
        if (resetall) begin
            state       <= IDLE;
            tree_idx    <= '0;
            tree_en_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        tree_en_q  <= tree_en_i;
                        tree_idx   <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ACCUM;
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            acc[k] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        acc[k] <= acc[k] + (tree_en_q[tree_idx] ? lane_ext(dec_q[tree_idx], k) : '0);
                    end
                    tree_idx <= tree_idx + 1'b1;
                    if (tree_idx == TREE_W'(NUM_TREES - 1)) begin
                        state <= ARGMAX;
                    end
                end
                ARGMAX: begin
                    if (scan_done) begin
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vote_argmax_scan u_scan (
        .clk      (clk),
        .resetall (resetall),
        .start    (scan_start),
        .val      (acc[scan_idx]),
        .cls_idx  (scan_idx),
        .best     (scan_best),
        .best_idx (scan_best_idx),
        .done     (scan_done)
    );

endmodule

// File: tb/tb_forest_vote_accumulator.sv
// Directed bench for the vote accumulator: reset, sums, masking, ties, backpressure.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
// All expected values are hand-computed constants.
module tb_forest_vote_accumulator;

    logic         clk = 1'b0;
    logic         resetall;
    logic [255:0] dec [8];
    logic [7:0]   tree_en;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   class_o;
    logic [10:0]  score_o;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forest_vote_accumulator dut (
        .clk         (clk),
        .resetall    (resetall),
        .decision1_i (dec[0]),
        .decision2_i (dec[1]),
        .decision3_i (dec[2]),
        .decision4_i (dec[3]),
        .decision5_i (dec[4]),
        .decision6_i (dec[5]),
        .decision7_i (dec[6]),
        .decision8_i (dec[7]),
        .tree_en_i   (tree_en),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .class_o     (class_o),
        .score_o     (score_o),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_dec();
        for (int t = 0; t < 8; t++) dec[t] = '0;
    endtask

    task automatic set_lane(input int t, input int k, input logic [7:0] v);
        dec[t][k*8 +: 8] = v;
    endtask

    // Present a set for one edge; DUT must be idle beforehand.
    task automatic start_set(input string tag, input logic [7:0] en);
        check({tag, "_ready_before"}, in_ready, 1);
        tree_en  = en;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_busy_after"}, busy, 1);
    endtask

    task automatic wait_result(input string tag, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "_no_timeout"}, out_valid, 1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int cyc;
        clear_dec();
        tree_en   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resetall  = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetall = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_class", class_o, 0);
        check("rst_score", score_o, 0);
        check("rst_busy", busy, 0);

        // 1: reset in the middle of accumulation
        for (int t = 0; t < 8; t++) set_lane(t, 12, 8'd90);
        start_set("midrst", 8'hFF);
        repeat (3) @(posedge clk);
        #1 resetall = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetall = 1'b0;
        check("midrst_ready", in_ready, 1);
        check("midrst_valid", out_valid, 0);
        check("midrst_class", class_o, 0);
        check("midrst_score", score_o, 0);
        check("midrst_busy", busy, 0);

        // 2: single hot lane, latency
        clear_dec();
        for (int t = 0; t < 8; t++) set_lane(t, 5, 8'd10);
        start_set("hot", 8'hFF);
        wait_result("hot", cyc);
        check("hot_latency", cyc, 40);
        check("hot_class", class_o, 5);
        check("hot_score", score_o, 80);
        check("hot_busy_done", busy, 0);
        consume("hot");

        // 3: masking
        clear_dec();
        set_lane(0, 3, 8'd200);
        for (int t = 1; t < 8; t++) set_lane(t, 7, 8'd255);
        start_set("mask", 8'h01);
        wait_result("mask", cyc);
        check("mask_class", class_o, 3);
        check("mask_score", score_o, 200);
        consume("mask");

        // 4: all lanes saturated, out_ready held high -> one-cycle result
        for (int t = 0; t < 8; t++) dec[t] = {256{1'b1}};
        out_ready = 1'b1;
        start_set("sat", 8'hFF);
        wait_result("sat", cyc);
        check("sat_class", class_o, 0);
        check("sat_score", score_o, 2040);
        @(posedge clk); #1;
        check("sat_one_cycle", out_valid, 0);
        check("sat_ready_back", in_ready, 1);
        out_ready = 1'b0;

        // tie between lanes 4 and 9 with a mixed enable
        clear_dec();
        set_lane(0, 9, 8'd25);
        set_lane(2, 9, 8'd25);
        set_lane(5, 4, 8'd50);
        set_lane(1, 4, 8'd200);
        set_lane(7, 30, 8'd49);
        start_set("tie", 8'hA5);
        wait_result("tie", cyc);
        check("tie_class", class_o, 4);
        check("tie_score", score_o, 50);
        consume("tie");

        // 5: backpressure with ignored input pulses
        clear_dec();
        for (int t = 0; t < 4; t++) set_lane(t, 20, 8'd7);
        start_set("bp", 8'hFF);
        wait_result("bp", cyc);
        clear_dec();
        set_lane(0, 1, 8'd99);
        tree_en = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            @(posedge clk); #1;
            check("bp_valid_hold", out_valid, 1);
            check("bp_class_hold", class_o, 20);
            check("bp_score_hold", score_o, 28);
            check("bp_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        consume("bp");

        // 6: empty enable with nonzero data
        start_set("empty", 8'h00);
        wait_result("empty", cyc);
        check("empty_latency", cyc, 40);
        check("empty_class", class_o, 0);
        check("empty_score", score_o, 0);
        consume("empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
